// File: rtl/ifetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : ifetch_unit
// Description : Instruction-fetch front end for a multi-cycle 16-bit core.
//               Owns the program counter, the memory data register (MDR) and
//               the instruction register (IR). A small IDLE/REQ/DONE state
//               machine issues one memory read per MemRead request and holds
//               the control unit (Stall) while the read is outstanding.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   PC_RESET  [15:0]  PC value loaded on reset
//   TIMEOUT   [7:0]   REQ cycles without MemAck before the fetch is aborted
//                     (only meaningful when FETCH_TIMEOUT_EN is defined)
// Ports
//   CLK        in   1   rising-edge clock
//   Reset      in   1   synchronous active-high reset, highest priority
//   MemRead    in   1   request a fetch of the word at PC (IDLE only)
//   IRWrite    in   1   load IR from MDR (IDLE/DONE) or MemRdata (REQ+MemAck)
//   PCWrite    in   1   update PC using PCSource
//   PCSource   in   2   00 ALUResult, 01 ALUOut, 10 jump, 11 hold
//   ALUResult  in   16  combinational ALU result
//   ALUOut     in   16  registered ALU result
//   MemAck     in   1   memory read data valid (honoured in REQ only)
//   MemRdata   in   16  memory read data
//   MemReq     out  1   memory read request
//   MemAddr    out  16  memory read address, latched from PC at request
//   PC         out  16  program counter
//   Instr      out  16  instruction register
//   Opcode     out  6   Instr[15:10]
//   Stall      out  1   fetch outstanding
//   FetchErr   out  1   sticky fetch-timeout flag
// Build option
//   FETCH_TIMEOUT_EN  when defined, a fetch that sees no MemAck within
//                     TIMEOUT cycles is abandoned and FetchErr is set.
// ============================================================================
module ifetch_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        IRWrite,
    input  logic        PCWrite,
    input  logic [1:0]  PCSource,
    input  logic [15:0] ALUResult,
    input  logic [15:0] ALUOut,
    input  logic        MemAck,
    input  logic [15:0] MemRdata,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    output logic [15:0] PC,
    output logic [15:0] Instr,
    output logic [5:0]  Opcode,
    output logic        Stall,
    output logic        FetchErr
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_REQ  = 2'd1,
        c_ST_DONE = 2'd2
    } fetch_state_t;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_HOLD   = 2'b11;

    // ------------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------------
    fetch_state_t r_state_q,     w_state_d;
    logic [15:0]  r_pc_q,        w_pc_d;
    logic [15:0]  r_instr_q,     w_instr_d;
    logic [15:0]  r_mdr_q,       w_mdr_d;
    logic [15:0]  r_mem_addr_q,  w_mem_addr_d;
    logic         r_mem_req_q,   w_mem_req_d;
    logic         r_stall_q,     w_stall_d;
    logic         r_fetch_err_q, w_fetch_err_d;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]   r_tmo_cnt_q,   w_tmo_cnt_d;
    logic [7:0]   w_tmo_cnt_inc;
`else
    // TIMEOUT has no function without the watchdog; keep it referenced so the
    // parameter list is identical in both builds.
    logic [7:0]   w_unused_timeout;
    assign w_unused_timeout = TIMEOUT;
`endif

    // ------------------------------------------------------------------------
    // Fetch state machine, MDR, memory request and error flag
    // ------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    assign w_tmo_cnt_inc = r_tmo_cnt_q + 8'd1;
`endif

    always_comb begin
        w_state_d     = r_state_q;
        w_mdr_d       = r_mdr_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_req_d   = r_mem_req_q;
        w_stall_d     = r_stall_q;
        w_fetch_err_d = r_fetch_err_q;
`ifdef FETCH_TIMEOUT_EN
        w_tmo_cnt_d   = r_tmo_cnt_q;
`endif

        case (r_state_q)
            c_ST_IDLE: begin
                if (MemRead) begin
                    // Address is captured here so later PC writes cannot
                    // disturb the read already in flight.
                    w_state_d    = c_ST_REQ;
                    w_mem_addr_d = r_pc_q;
                    w_mem_req_d  = 1'b1;
                    w_stall_d    = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    w_tmo_cnt_d  = 8'd0;
`endif
                end
            end

            c_ST_REQ: begin
                if (MemAck) begin
                    w_state_d   = c_ST_DONE;
                    w_mdr_d     = MemRdata;
                    w_mem_req_d = 1'b0;
                    w_stall_d   = 1'b0;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (w_tmo_cnt_inc == TIMEOUT) begin
                    // Give up on the memory: return to IDLE with a clean MDR
                    // and flag the error until the next reset.
                    w_state_d     = c_ST_IDLE;
                    w_mdr_d       = 16'h0000;
                    w_mem_req_d   = 1'b0;
                    w_stall_d     = 1'b0;
                    w_fetch_err_d = 1'b1;
                    w_tmo_cnt_d   = w_tmo_cnt_inc;
                end else begin
                    w_tmo_cnt_d   = w_tmo_cnt_inc;
                end
`endif
            end

            c_ST_DONE: begin
                // One-cycle landing state; a new MemRead is not accepted here.
                w_state_d = c_ST_IDLE;
            end

            default: begin
                w_state_d   = c_ST_IDLE;
                w_mem_req_d = 1'b0;
                w_stall_d   = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------------
    always_comb begin
        w_instr_d = r_instr_q;
        if (IRWrite) begin
            case (r_state_q)
                c_ST_IDLE,
                c_ST_DONE: w_instr_d = r_mdr_q;
                // Forward the returning word so the IR can be loaded in the
                // same cycle the memory acknowledges; without an acknowledge
                // there is nothing valid to load.
                c_ST_REQ:  if (MemAck) w_instr_d = MemRdata;
                default:   w_instr_d = r_instr_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Program counter (independent of the fetch state)
    // ------------------------------------------------------------------------
    always_comb begin
        w_pc_d = r_pc_q;
        if (PCWrite) begin
            case (PCSource)
                c_PCSRC_ALU:    w_pc_d = ALUResult;
                c_PCSRC_ALUOUT: w_pc_d = ALUOut;
                c_PCSRC_JUMP:   w_pc_d = {r_pc_q[15:12], r_instr_q[11:0]};
                c_PCSRC_HOLD:   w_pc_d = r_pc_q;
                default:        w_pc_d = r_pc_q;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state_q     <= c_ST_IDLE;
            r_pc_q        <= PC_RESET;
            r_instr_q     <= 16'h0000;
            r_mdr_q       <= 16'h0000;
            r_mem_addr_q  <= 16'h0000;
            r_mem_req_q   <= 1'b0;
            r_stall_q     <= 1'b0;
            r_fetch_err_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            r_state_q     <= w_state_d;
            r_pc_q        <= w_pc_d;
            r_instr_q     <= w_instr_d;
            r_mdr_q       <= w_mdr_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_req_q   <= w_mem_req_d;
            r_stall_q     <= w_stall_d;
            r_fetch_err_q <= w_fetch_err_d;
`ifdef FETCH_TIMEOUT_EN
            r_tmo_cnt_q   <= w_tmo_cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign MemReq   = r_mem_req_q;
    assign MemAddr  = r_mem_addr_q;
    assign PC       = r_pc_q;
    assign Instr    = r_instr_q;
    assign Opcode   = r_instr_q[15:10];
    assign Stall    = r_stall_q;
    assign FetchErr = r_fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ifetch_unit
// Description : Directed self-checking bench for ifetch_unit. Inputs change
//               and outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSource;
    logic [15:0] ALUResult;
    logic [15:0] ALUOut;
    logic        MemAck;
    logic [15:0] MemRdata;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic [15:0] PC;
    logic [15:0] Instr;
    logic [5:0]  Opcode;
    logic        Stall;
    logic        FetchErr;

    int n_checks = 0;
    int n_fails  = 0;

    ifetch_unit #(
        .PC_RESET (16'h0000),
        .TIMEOUT  (8'd4)
    ) u_dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .PCSource  (PCSource),
        .ALUResult (ALUResult),
        .ALUOut    (ALUOut),
        .MemAck    (MemAck),
        .MemRdata  (MemRdata),
        .MemReq    (MemReq),
        .MemAddr   (MemAddr),
        .PC        (PC),
        .Instr     (Instr),
        .Opcode    (Opcode),
        .Stall     (Stall),
        .FetchErr  (FetchErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    int req_cnt;
    int stall_cnt;

    initial begin
        Reset = 1'b1; MemRead = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0;
        PCSource = 2'b00; ALUResult = 16'h0000; ALUOut = 16'h0000;
        MemAck = 1'b0; MemRdata = 16'h0000;
        step(); step();
        Reset = 1'b0;

        // Reset state
        check("rst_pc",      PC,       16'h0000);
        check("rst_instr",   Instr,    16'h0000);
        check("rst_memreq",  MemReq,   16'h0000);
        check("rst_memaddr", MemAddr,  16'h0000);
        check("rst_stall",   Stall,    16'h0000);
        check("rst_fetcherr",FetchErr, 16'h0000);

        // Basic fetch: ack after 3 wait cycles, IR loaded from MDR in DONE
        MemRdata = 16'h1234;
        MemRead = 1'b1; step(); MemRead = 1'b0;
        req_cnt = 0; stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            req_cnt   += int'(MemReq);
            stall_cnt += int'(Stall);
            check("f1_addr_hold", MemAddr, 16'h0000);
            MemAck = (i == 3);
            step();
        end
        MemAck = 1'b0;
        check("f1_req_cycles",   16'(req_cnt),   16'd4);
        check("f1_stall_cycles", 16'(stall_cnt), 16'd4);
        check("f1_req_drop",     MemReq,         16'h0000);
        IRWrite = 1'b1; step(); IRWrite = 1'b0;
        check("f1_instr",  Instr,  16'h1234);
        check("f1_opcode", Opcode, 16'h0004);

        // Forwarding: IRWrite coincident with MemAck; MemRead held is not queued
        MemRead = 1'b1; step();
        step();
        MemAck = 1'b1; IRWrite = 1'b1; MemRdata = 16'hABCD; step();
        MemAck = 1'b0; IRWrite = 1'b0;
        check("fwd_instr", Instr, 16'hABCD);
        step();
        check("noqueue_req", MemReq, 16'h0000);
        MemRead = 1'b0;

        // PC sources
        PCWrite = 1'b1; PCSource = 2'b00; ALUResult = 16'h3000; step(); PCWrite = 1'b0;
        check("pc_alu", PC, 16'h3000);
        MemRead = 1'b1; step(); MemRead = 1'b0;
        check("f3_addr", MemAddr, 16'h3000);
        MemAck = 1'b1; IRWrite = 1'b1; MemRdata = 16'h0456; step();
        MemAck = 1'b0; IRWrite = 1'b0;
        step();
        PCWrite = 1'b1; PCSource = 2'b10; step();
        check("pc_jump", PC, 16'h3456);
        PCSource = 2'b11; step();
        check("pc_hold", PC, 16'h3456);
        PCSource = 2'b01; ALUOut = 16'hBEEF; step();
        check("pc_aluout", PC, 16'hBEEF);
        PCWrite = 1'b0;

        // PC write during an outstanding fetch; IRWrite in REQ without ack
        PCWrite = 1'b1; PCSource = 2'b00; ALUResult = 16'h0000; step(); PCWrite = 1'b0;
        MemRead = 1'b1; step(); MemRead = 1'b0;
        PCWrite = 1'b1; ALUResult = 16'h0010; IRWrite = 1'b1; step();
        PCWrite = 1'b0; IRWrite = 1'b0;
        check("inflight_pc",   PC,      16'h0010);
        check("inflight_addr", MemAddr, 16'h0000);
        check("inflight_req",  MemReq,  16'h0001);
        check("ir_noack",      Instr,   16'h0456);
        MemAck = 1'b1; MemRdata = 16'h5555; step(); MemAck = 1'b0;
        step();
        MemRead = 1'b1; step(); MemRead = 1'b0;
        check("next_addr", MemAddr, 16'h0010);
        MemAck = 1'b1; step(); MemAck = 1'b0;
        step();

        // Reset mid-fetch, late MemAck ignored, MDR stays clear
        MemRead = 1'b1; step(); MemRead = 1'b0;
        check("mid_req", MemReq, 16'h0001);
        Reset = 1'b1; step(); Reset = 1'b0;
        check("midrst_req",   MemReq, 16'h0000);
        check("midrst_stall", Stall,  16'h0000);
        check("midrst_pc",    PC,     16'h0000);
        MemAck = 1'b1; MemRdata = 16'hFFFF; step(); MemAck = 1'b0;
        check("lateack_req",   MemReq, 16'h0000);
        check("lateack_stall", Stall,  16'h0000);
        IRWrite = 1'b1; step(); IRWrite = 1'b0;
        check("lateack_mdr", Instr, 16'h0000);

        // Missing acknowledge: timeout abort or indefinite wait
        MemRead = 1'b1; step(); MemRead = 1'b0;
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (MemReq !== 1'b1) break;
            req_cnt++;
            step();
        end
`ifdef FETCH_TIMEOUT_EN
        check("tmo_cycles",   16'(req_cnt), 16'd4);
        check("tmo_fetcherr", FetchErr,     16'h0001);
        check("tmo_stall",    Stall,        16'h0000);
        step(); step(); step();
        check("tmo_sticky",   FetchErr,     16'h0001);
        Reset = 1'b1; step(); Reset = 1'b0;
        check("tmo_clear",    FetchErr,     16'h0000);
`else
        check("wait_cycles",  16'(req_cnt), 16'd20);
        check("wait_fetcherr",FetchErr,     16'h0000);
        check("wait_stall",   Stall,        16'h0001);
        MemAck = 1'b1; MemRdata = 16'h7777; step(); MemAck = 1'b0;
        check("wait_done_req", MemReq,      16'h0000);
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter PC_RESET, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 8'd255, cycles without MemAck before fetch abort (used only when FETCH_TIMEOUT_EN defined).
REQ-003 One clock; reset is synchronous and active-high; ports named CLK and Reset.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 Reset  input  1  synchronous active-high reset.
REQ-006 MemRead  input  1  control-unit request to fetch the word at PC.
REQ-007 IRWrite  input  1  control-unit strobe to load IR.
REQ-008 PCWrite  input  1  control-unit strobe to update PC.
REQ-009 PCSource  input  2  PC next-value select.
REQ-010 ALUResult  input  16  ALU output, PC source 00.
REQ-011 ALUOut  input  16  registered ALU output, PC source 01.
REQ-012 MemAck  input  1  memory data-valid acknowledge.
REQ-013 MemRdata  input  16  memory read data, valid when MemAck=1.
REQ-014 MemReq  output  1  memory read request.
REQ-015 MemAddr  output  16  memory read address.
REQ-016 PC  output  16  current program counter.
REQ-017 Instr  output  16  instruction register.
REQ-018 Opcode  output  6  Instr[15:10], to control unit.
REQ-019 Stall  output  1  fetch outstanding; control unit holds state.
REQ-020 FetchErr  output  1  sticky fetch-timeout flag (0 when FETCH_TIMEOUT_EN undefined).

Function
REQ-021 FSM states IDLE, REQ, DONE; Stall SHALL be 1 in REQ, 0 otherwise.
REQ-022 IDLE with MemRead=1 -> REQ next edge; MemAddr latched from PC on that edge; MemReq=1 from that edge.
REQ-023 REQ: MemReq held 1, MemAddr held constant until MemAck sampled 1.
REQ-024 REQ with MemAck=1 -> DONE; MDR <= MemRdata; MemReq deasserted same edge.
REQ-025 DONE -> IDLE unconditionally after one cycle; MemRead in DONE is ignored.
REQ-026 MemRead while in REQ or DONE SHALL be ignored (no queueing).
REQ-027 IRWrite in IDLE or DONE: Instr <= MDR next edge.
REQ-028 IRWrite coinciding with MemAck in REQ: Instr <= MemRdata directly (forwarding).
REQ-029 IRWrite in REQ without MemAck SHALL be ignored; Instr unchanged.
REQ-030 PCWrite: PC <= ALUResult (00), ALUOut (01), {PC[15:12],Instr[11:0]} (10), PC hold (11).
REQ-031 PCWrite is honoured in any state; an in-flight fetch keeps its latched MemAddr.
REQ-032 All PC arithmetic 16-bit, wrap-around mod 2^16, no overflow flag.
REQ-033 MemAck outside REQ SHALL be ignored.

Reset
REQ-034 Reset SHALL force: state IDLE, PC=PC_RESET, Instr=0, MDR=0, MemReq=0, MemAddr=0, Stall=0, FetchErr=0.
REQ-035 Reset mid-fetch SHALL drop MemReq at the same edge; later MemAck ignored.
REQ-036 Reset has priority over every other input.

Configuration
REQ-037 Macro FETCH_TIMEOUT_EN defined: 8-bit counter clears on REQ entry, increments each REQ cycle without MemAck; on reaching TIMEOUT -> IDLE, MemReq=0, MDR=16'h0000, FetchErr=1 (sticky until Reset).
REQ-038 Macro undefined: no counter; REQ waits for MemAck indefinitely; FetchErr tied 0.

Verification
REQ-039 Reset, MemRead pulse, MemAck after 3 wait cycles with MemRdata=16'h1234, then IRWrite -> MemReq high 4 cycles, MemAddr=0000, Stall high 4 cycles, Instr=1234, Opcode=6'h04.
REQ-040 MemAck same cycle as IRWrite, MemRdata=16'hABCD -> Instr=ABCD next edge.
REQ-041 PC=16'h3000, Instr=16'h0456, PCWrite PCSource=10 -> PC=16'h3456; PCSource=11 -> PC unchanged.
REQ-042 PCWrite ALUResult=16'h0010 during outstanding fetch at 16'h0000 -> MemAddr stays 0000, PC=0010.
REQ-043 Reset asserted in REQ, MemAck next cycle -> MemReq 0, state IDLE, MDR stays 0.
REQ-044 FETCH_TIMEOUT_EN, TIMEOUT=8'd4, no MemAck -> MemReq drops after 4 cycles, FetchErr=1 until Reset.
